// File: rtl/iiitb_icg_pkg.sv
// iiitb_icg_pkg: shared FSM state type and configuration legality check for the auto clock-gating controller
package iiitb_icg_pkg;
  typedef enum logic [1:0] {
    GATED     = 2'd0,
    ACTIVE    = 2'd1,
    IDLE_PEND = 2'd2
  } icg_state_e;
  function automatic bit icg_cfg_ok(input int nch, input int idle_cycles);
    return (nch >= 1) && (nch <= 16) && (idle_cycles >= 1);
  endfunction
endpackage

// File: rtl/iiitb_icg_cell.sv
// iiitb_icg_cell: glitch-free clock gate (negedge enable latch flop, AND gate, scan override)
// Ports: clk root clock, rst_n async active-low clear, test_en_i forces gclk_o=clk,
//        en_i enable from the posedge domain, gclk_o gated clock, en_l_o captured enable.
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic test_en_i,
  input  logic en_i,
  output logic gclk_o,
  output logic en_l_o
);
  logic en_l_q;
  // Capturing on the falling edge means the enable only moves while clk is low.
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) en_l_q <= 1'b0;
    else en_l_q <= en_i;
  assign en_l_o = en_l_q;
  assign gclk_o = clk & (en_l_q | test_en_i);
endmodule

// File: rtl/iiitb_auto_icg.sv
// iiitb_auto_icg: multi-channel automatic clock-gating controller with per-channel registers and gating statistics
// Ports: clk root clock, rst_n async active-low reset, test_en scan override,
//        req/force_on per-channel activity, d per-channel data (channel i at [i*W +: W]),
//        gclk gated clocks, q per-channel registers, ch_active latched enables,
//        gated_cnt per-channel saturating count of gated posedges (channel i at [i*SW +: SW]).
module iiitb_auto_icg
  import iiitb_icg_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int SW          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_en,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    force_on,
  input  logic [NCH*W-1:0]  d,
  output logic [NCH-1:0]    gclk,
  output logic [NCH*W-1:0]  q,
  output logic [NCH-1:0]    ch_active,
  output logic [NCH*SW-1:0] gated_cnt
);
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [SW-1:0] SAT = '1;
  if (!icg_cfg_ok(NCH, IDLE_CYCLES)) begin : g_bad_cfg
    $error("iiitb_auto_icg: NCH must be 1..16 and IDLE_CYCLES must be >= 1");
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    icg_state_e state_q, state_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [W-1:0] q_q;
    logic [SW-1:0] gated_cnt_q;
    logic act, en;
    assign act = req[i] | force_on[i];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state_q    <= GATED;
        idle_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
      end
    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      case (state_q)
        GATED: begin
          state_d    = act ? ACTIVE : GATED;
          idle_cnt_d = '0;
        end
        ACTIVE: if (!act) begin
          state_d    = (IDLE_CYCLES == 1) ? GATED : IDLE_PEND;
          idle_cnt_d = (IDLE_CYCLES == 1) ? '0 : CW'(1);
        end
        IDLE_PEND: begin
          state_d    = act ? ACTIVE : (idle_cnt_q == LAST) ? GATED : IDLE_PEND;
          idle_cnt_d = (act || idle_cnt_q == LAST) ? '0 : idle_cnt_q + CW'(1);
        end
        default: begin
          state_d    = GATED;
          idle_cnt_d = '0;
        end
      endcase
    end
    // The registered enable is exactly "not GATED", so it is decoded from the state register.
    always_comb en = (state_q != GATED);
    iiitb_icg_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .test_en_i(test_en),
      .en_i     (en),
      .gclk_o   (gclk[i]),
      .en_l_o   (ch_active[i])
    );
    always_ff @(posedge gclk[i] or negedge rst_n)
      if (!rst_n) q_q <= '0;
      else q_q <= d[i*W +: W];
    assign q[i*W +: W] = q_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) gated_cnt_q <= '0;
      else if (!ch_active[i] && !test_en && gated_cnt_q != SAT) gated_cnt_q <= gated_cnt_q + SW'(1);
    assign gated_cnt[i*SW +: SW] = gated_cnt_q;
  end
endmodule

// File: doc/iiitb_auto_icg.md
# iiitb_auto_icg

Parametrised multi-channel automatic clock-gating controller. Each of `NCH` channels owns a `W`-bit register bank clocked by its own glitch-free gated clock. A per-channel idle-detect FSM shuts the clock off after `IDLE_CYCLES` consecutive inactive cycles and restores it one cycle after activity returns. The block sits between the root clock and the datapath registers it protects, and reports per-channel gating statistics.

## Interface
- `NCH`, 4, number of independent channels (1..16)
- `W`, 8, data width per channel
- `IDLE_CYCLES`, 4, consecutive idle samples before gating (>=1; 0 is illegal, elaboration error)
- `SW`, 16, width of per-channel gated-cycle statistic counter

- `clk` in 1: root clock; all state on posedge, enable capture on negedge
- `rst_n` in 1: asynchronous, active-low reset
- `test_en` in 1: scan override; forces every gated clock to follow `clk`
- `req` in NCH: per-channel activity request, sampled on posedge `clk`
- `force_on` in NCH: per-channel keep-awake, treated as `req`=1
- `d` in NCH*W: channel data, channel i at bits [i*W +: W]
- `gclk` out NCH: gated clocks, `clk & en_l[i]` (or `clk` when `test_en`)
- `q` out NCH*W: channel registers, captured on posedge `gclk[i]`
- `ch_active` out NCH: per-channel `en_l`, the latched enable
- `gated_cnt` out NCH*SW: per-channel saturating count of posedges with the clock gated

## Operation
- Per-channel FSM, states GATED, ACTIVE, IDLE_PEND; `act[i] = req[i] | force_on[i]`.
- GATED: `act`=1 -> ACTIVE, `en_d`=1; else stay, `en_d`=0.
- ACTIVE: `act`=0 -> IDLE_PEND with `idle_cnt`=1; if `IDLE_CYCLES`=1, go directly to GATED. `en_d`=1.
- IDLE_PEND: `act`=1 -> ACTIVE, `idle_cnt`=0. Else if `idle_cnt`==`IDLE_CYCLES`-1 -> GATED, `en_d`=0. Else increment `idle_cnt`.
- `en_d` is a posedge register. `en_l` captures `en_d` on negedge `clk`. Consequence: `en_l` only changes while `clk` is low, so `gclk` never glitches.
- `q[i]` loads `d[i]` on every `gclk[i]` rising edge.
- `gated_cnt[i]` increments on each posedge `clk` where `en_l[i]`=0 and `test_en`=0. It saturates at 2^SW-1.
- `test_en`=1 forces `gclk`=`clk` for all channels. FSMs and `en_l` keep running unchanged. `gated_cnt` does not increment.
- `idle_cnt` width is $clog2(IDLE_CYCLES+1).

## Timing
- Reset (async, mid-operation included): FSM=GATED, `en_d`=0, `en_l`=0, `idle_cnt`=0, `q`=0, `gated_cnt`=0, `ch_active`=0, `gclk` low. While `test_en`=0, no `gclk` pulse occurs during reset or on the first posedge after release.
- Wake latency: `act` sampled high at posedge k -> `en_l` high at negedge k -> first `gclk` pulse, and `q` capture of `d`, at posedge k+1.
- Gate latency: `act` low at posedges k..k+IDLE_CYCLES-1 -> the last `gclk` pulse is at posedge k+IDLE_CYCLES-1 -> no pulse from posedge k+IDLE_CYCLES.
- `act` re-asserted in IDLE_PEND: no lost pulse, and the idle count restarts.
- Channels are fully independent; simultaneous wake and gate on different channels are legal.
- `req` must be synchronous to `clk`.

## Structure
- Package `iiitb_icg_pkg`: state enum (GATED, ACTIVE, IDLE_PEND) and the `IDLE_CYCLES` legality check.
- Sub-module `iiitb_icg_cell`: negedge enable flop with async clear, AND gate, and `test_en` OR. One instance per channel.
- Top level: generate loop over `NCH` instantiating FSM, cell, data register and statistic counter.

## Test plan
- Reset, then `req`=0 for 10 cycles -> `gclk` flat, `q`=0, `gated_cnt[0]`=10.
- `req[0]` high at posedge 5 with `d[0]`=8'hA5 -> first `gclk[0]` pulse at posedge 6, `q[0]`=8'hA5, `ch_active[0]`=1 from negedge 5.
- IDLE_CYCLES=4; `req[1]` drops at posedge 10 -> `gclk[1]` pulses at 11, 12 and 13, none at 14; `req[1]` high at 12 instead -> pulses continue uninterrupted.
- `force_on[2]`=1 with `req`=0 -> `gclk[2]` free-runs and `gated_cnt[2]` stays 0; with `test_en`=1 -> all `gclk` toggle and counters freeze.
- Assert `rst_n` low mid-high-phase of `clk` while channels are active -> `gclk` drops immediately, and all outputs return to their reset values.
- SW=4 with a channel gated for 20 cycles -> `gated_cnt` saturates at 15.
